// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS memory stage: word/address geometry,
// the data-memory responder state encoding and its latency counter width.
package mips_pkg;
  localparam int WORD_W   = 32;
  localparam int ADDR_LSB = 2;
  localparam int CNT_W    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/dmem_ram.sv
// Synchronous single-port data RAM with write enable and registered read.
// The read returns the contents from before a same-edge write.
module dmem_ram
  import mips_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem [DEPTH_WORDS];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/dmem_responder.sv
// M-stage data-memory responder: one load/store per request, LATENCY busy cycles,
// StallM holds the pipeline until DONE. Optional macro: DMEM_ALIGN_CHECK_EN.
module dmem_responder
  import mips_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemWriteM,
  input  logic              MemtoRegM,
  input  logic [WORD_W-1:0] ALUOutM,
  input  logic [WORD_W-1:0] WriteDataM,
  output logic [WORD_W-1:0] ReadDataM,
  output logic              StallM,
  output logic              MisalignM
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              st_q, st_d, ld_q, ld_d;
  logic              mis_q, mis_d;

  logic              req, misalign_req, ram_we;
  logic [IDX_W-1:0]  ram_idx;
  logic [WORD_W-1:0] ram_rdata;
  logic              unused_addr;

  assign req = MemWriteM | MemtoRegM;
  assign unused_addr = &{1'b0, ALUOutM};

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign_req = |ALUOutM[ADDR_LSB-1:0];
`else
  assign misalign_req = 1'b0;
`endif

  // In IDLE the RAM reads the live address so the registered read is
  // already valid by the last BUSY cycle, even when LATENCY is 1.
  assign ram_idx = (state_q == IDLE) ? ALUOutM[ADDR_LSB +: IDX_W] : idx_q;
  assign ram_we  = (state_q == BUSY) && (cnt_q == '0) && st_q && !reset;

  dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS), .IDX_W(IDX_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_idx),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    st_d    = st_q;
    ld_d    = ld_q;
    mis_d   = 1'b0;
    case (state_q)
      IDLE: if (req) begin
        idx_d   = ALUOutM[ADDR_LSB +: IDX_W];
        wdata_d = WriteDataM;
        st_d    = MemWriteM;
        ld_d    = MemtoRegM;
        if (misalign_req) begin
          rdata_d = '0;
          mis_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: if (cnt_q == '0) begin
        // Store-with-load returns the store data, not the old RAM word.
        if (ld_q) rdata_d = st_q ? wdata_q : ram_rdata;
        state_d = DONE;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      st_q    <= 1'b0;
      ld_q    <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      st_q    <= st_d;
      ld_q    <= ld_d;
      mis_q   <= mis_d;
    end
  end

  assign StallM    = req & (state_q != DONE) & ~reset;
  assign ReadDataM = rdata_q;
  assign MisalignM = mis_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (DEPTH_WORDS=64, LATENCY=2): table of
// back-to-back accesses plus hand sequences for reset-in-BUSY and alignment.
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic        MemWriteM, MemtoRegM;
  logic [31:0] ALUOutM, WriteDataM, ReadDataM;
  logic        StallM, MisalignM;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWriteM  (MemWriteM),
    .MemtoRegM  (MemtoRegM),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .MisalignM  (MisalignM)
  );

  typedef struct {
    logic        we;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Presents one request just after a rising edge, counts stall cycles and
  // checks outputs in the DONE cycle; returns just after the edge ending DONE.
  task automatic do_req(input string name, input logic we, input logic rd,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input int exp_stall,
                        input logic exp_mis);
    int  n = 0;
    bit  done = 0;
    MemWriteM  = we;
    MemtoRegM  = rd;
    ALUOutM    = addr;
    WriteDataM = wdata;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (StallM) n++;
      else done = 1;
      if (!done) begin
        @(posedge clk);
        #1;
      end
    end
    chk({name, "_done"}, 32'(done), 32'd1);
    chk({name, "_stalls"}, n, exp_stall);
    chk({name, "_rdata"}, ReadDataM, exp_rd);
    chk({name, "_mis"}, 32'(MisalignM), 32'(exp_mis));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string name);
    MemWriteM = 1'b0;
    MemtoRegM = 1'b0;
    @(negedge clk);
    chk({name, "_stall"}, 32'(StallM), 32'd0);
    chk({name, "_mis"}, 32'(MisalignM), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 32'h10,  32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b0, 32'h0,   32'h1,        32'hDEADBEEF};
    vecs[3] = '{1'b0, 1'b1, 32'h0,   32'h0,        32'h1};
    vecs[4] = '{1'b1, 1'b0, 32'h100, 32'hA5,       32'h1};
    vecs[5] = '{1'b0, 1'b1, 32'h0,   32'h0,        32'hA5};
    vecs[6] = '{1'b1, 1'b1, 32'h8,   32'h12345678, 32'h12345678};
    vecs[7] = '{1'b0, 1'b1, 32'h8,   32'h0,        32'h12345678};
    vecs[8] = '{1'b1, 1'b0, 32'hFC,  32'hCAFEF00D, 32'h12345678};
    vecs[9] = '{1'b0, 1'b1, 32'h3FC, 32'h0,        32'hCAFEF00D};

    reset = 1'b1;
    MemWriteM = 1'b0;
    MemtoRegM = 1'b1;
    ALUOutM = 32'h0;
    WriteDataM = 32'h0;
    @(negedge clk);
    chk("rst_stall_req", 32'(StallM), 32'd0);
    MemtoRegM = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_rdata", ReadDataM, 32'h0);
    chk("rst_stall", 32'(StallM), 32'd0);
    chk("rst_mis", 32'(MisalignM), 32'd0);
    @(posedge clk);
    #1;

    // Back-to-back: each request is presented in the IDLE cycle after DONE.
    for (int i = 0; i < 10; i++)
      do_req($sformatf("vec%0d", i), vecs[i].we, vecs[i].rd, vecs[i].addr,
             vecs[i].wdata, vecs[i].exp, 3, 1'b0);
    idle("idle0");

    // Reset during BUSY of a store must abort the write.
    do_req("pre20", 1'b1, 1'b0, 32'h20, 32'h11, 32'hCAFEF00D, 3, 1'b0);
    MemWriteM  = 1'b1;
    ALUOutM    = 32'h20;
    WriteDataM = 32'h55;
    @(negedge clk);
    chk("abort_t0_stall", 32'(StallM), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_rst_stall", 32'(StallM), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("abort_rst_stall2", 32'(StallM), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    MemWriteM = 1'b0;
    @(negedge clk);
    chk("abort_rdata", ReadDataM, 32'h0);
    @(posedge clk);
    #1;
    do_req("ld20", 1'b0, 1'b1, 32'h20, 32'h0, 32'h11, 3, 1'b0);
    idle("idle1");

`ifdef DMEM_ALIGN_CHECK_EN
    do_req("st10", 1'b1, 1'b0, 32'h10, 32'h77, 32'h11, 3, 1'b0);
    do_req("mis_st13", 1'b1, 1'b0, 32'h13, 32'h99, 32'h0, 1, 1'b1);
    idle("mis_after");
    do_req("ld10", 1'b0, 1'b1, 32'h10, 32'h0, 32'h77, 3, 1'b0);
    do_req("mis_ld11", 1'b0, 1'b1, 32'h11, 32'h0, 32'h0, 1, 1'b1);
    idle("mis_after2");
`else
    do_req("st13", 1'b1, 1'b0, 32'h13, 32'h77, 32'h11, 3, 1'b0);
    do_req("ld10", 1'b0, 1'b1, 32'h10, 32'h0, 32'h77, 3, 1'b0);
    do_req("ld12", 1'b0, 1'b1, 32'h12, 32'h0, 32'h77, 3, 1'b0);
    idle("idle2");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
